// File: rtl/feature_pkg.sv
// Shared constants and types for the feature output bundle and its serializer.
package feature_pkg;

  localparam int NUM_FEATURES = 27;
  localparam int FEAT_W       = 32;
  localparam int IDX_W        = 5;

  // Word order within a frame
  localparam int IDX_PSD_GAMMA = 0;
  localparam int IDX_PSD_BETA  = 1;
  localparam int IDX_PSD_ALPHA = 2;
  localparam int IDX_PSD_THETA = 3;
  localparam int IDX_PSD_DELTA = 4;
  localparam int IDX_PEAK      = 5;
  localparam int IDX_ZCR       = 6;
  // DWT block: band-major (gamma,beta,alpha,theta,delta), per band max,min,mean,sum
  localparam int IDX_DWT_BASE  = 7;

  // Index reported alongside the checksum beat
  localparam logic [IDX_W-1:0] IDX_CKSUM = 5'd27;

  typedef logic [FEAT_W-1:0] feat_word_t;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    CKSUM
  } ser_state_e;

endpackage

// File: rtl/feature_edge_detect.sv
// Frame-start pulse: rising edge of feat_valid, gated by en.
// The delayed copy always tracks feat_valid, so a level that is already
// high when en rises never looks like an edge.
module feature_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic feat_valid,
  output logic start
);

  logic feat_valid_q;

  // One-cycle delay of feat_valid for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) feat_valid_q <= 1'b0;
    else        feat_valid_q <= feat_valid;
  end

  assign start = en & feat_valid & ~feat_valid_q;

endmodule

// File: rtl/feature_serializer.sv
// Snapshots the parallel feature frame on a feat_valid rising edge and
// streams it one word per beat over valid/ready.
// Optional trailing checksum beat: define FEAT_SER_CHECKSUM_EN.
module feature_serializer #(
  parameter int NUM_FEATURES = 27,
  parameter int DATA_W       = 32,
  parameter int DROP_CNT_W   = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic [NUM_FEATURES*DATA_W-1:0] feat_vec,
  input  logic                           feat_valid,
  output logic [DATA_W-1:0]              m_data,
  output logic [4:0]                     m_index,
  output logic                           m_valid,
  output logic                           m_last,
  input  logic                           m_ready,
  output logic                           busy,
  output logic [DROP_CNT_W-1:0]          drop_cnt
);
  import feature_pkg::*;

  localparam logic [4:0] LAST_IDX = 5'(NUM_FEATURES - 1);

  ser_state_e        state, state_nx;
  logic [DATA_W-1:0] shadow [NUM_FEATURES];
  logic [4:0]        idx;
  logic              start, beat, last_beat, capture, at_last;

  feature_edge_detect u_edge (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .feat_valid (feat_valid),
    .start      (start)
  );

  assign m_valid = (state != IDLE);
  assign busy    = (state != IDLE);
  assign beat    = m_valid & m_ready;
  assign at_last = (state == SEND) && (idx == LAST_IDX);

`ifdef FEAT_SER_CHECKSUM_EN
  logic [DATA_W-1:0] cksum, sum_nx;

  // Frame checksum computed from the incoming vector, registered at capture
  always_comb begin
    sum_nx = '0;
    for (int k = 0; k < NUM_FEATURES; k++) sum_nx = sum_nx + feat_vec[k*DATA_W +: DATA_W];
  end

  // Checksum holding register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cksum <= '0;
    else if (capture) cksum <= sum_nx;
  end

  assign last_beat = beat & (state == CKSUM);
  assign m_last    = (state == CKSUM);
`else
  assign last_beat = beat & at_last;
  assign m_last    = at_last;
`endif

  // A start is accepted when idle or exactly on the final beat (back-to-back frames)
  assign capture = start & ((state == IDLE) | last_beat);

  // Output word mux; zero when nothing is presented
  always_comb begin
    m_data  = '0;
    m_index = '0;
    case (state)
      SEND: begin
        m_data  = shadow[idx];
        m_index = idx;
      end
`ifdef FEAT_SER_CHECKSUM_EN
      CKSUM: begin
        m_data  = cksum;
        m_index = IDX_CKSUM;
      end
`endif
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = SEND;
      SEND: begin
`ifdef FEAT_SER_CHECKSUM_EN
        if (beat && at_last) state_nx = CKSUM;
`else
        if (last_beat) state_nx = capture ? SEND : IDLE;
`endif
      end
`ifdef FEAT_SER_CHECKSUM_EN
      CKSUM: if (last_beat) state_nx = capture ? SEND : IDLE;
`endif
      default: state_nx = IDLE;
    endcase
  end

  // Shadow register file and word pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_FEATURES; k++) shadow[k] <= '0;
      idx <= '0;
    end else if (capture) begin
      for (int k = 0; k < NUM_FEATURES; k++) shadow[k] <= feat_vec[k*DATA_W +: DATA_W];
      idx <= '0;
    end else if (beat && (state == SEND) && (idx != LAST_IDX)) begin
      idx <= idx + 5'd1;
    end
  end

  // Saturating count of frames lost to overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      drop_cnt <= '0;
    else if (start && busy && !last_beat && (drop_cnt != {DROP_CNT_W{1'b1}}))
      drop_cnt <= drop_cnt + 1'b1;
  end

endmodule

// File: tb/tb_feature_serializer.sv
// Directed bench for feature_serializer; covers both checksum configurations.
module tb_feature_serializer;

  localparam int N = 27;
  localparam int W = 32;
`ifdef FEAT_SER_CHECKSUM_EN
  localparam int BEATS = 28;
`else
  localparam int BEATS = 27;
`endif

  logic           clk = 1'b0;
  logic           rst_n, en, feat_valid, m_ready;
  logic [N*W-1:0] feat_vec;
  logic [W-1:0]   m_data;
  logic [4:0]     m_index;
  logic           m_valid, m_last, busy;
  logic [7:0]     drop_cnt;

  int checks   = 0;
  int failures = 0;

  feature_serializer dut (
    .clk(clk), .rst_n(rst_n), .en(en), .feat_vec(feat_vec), .feat_valid(feat_valid),
    .m_data(m_data), .m_index(m_index), .m_valid(m_valid), .m_last(m_last),
    .m_ready(m_ready), .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int n, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, n, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic load(input logic [31:0] base, input bit ones);
    for (int k = 0; k < N; k++) feat_vec[k*W +: W] = ones ? 32'hFFFF_FFFF : base + k;
  endtask

  // Expected word b of a frame built by load(base, ones); b==27 is the checksum
  task automatic word_exp(input int b, input logic [31:0] base, input bit ones, output logic [31:0] d);
    if (b < N)   d = ones ? 32'hFFFF_FFFF : base + b;
    else if (ones) d = 32'hFFFF_FFE5;
    else         d = base * 27 + 32'd351;
  endtask

  task automatic check_beat(input string tag, input int b, input logic [31:0] base, input bit ones);
    logic [31:0] d;
    word_exp(b, base, ones, d);
    chk({tag, "_valid"}, b, {31'd0, m_valid}, 32'd1);
    chk({tag, "_data"},  b, m_data, d);
    chk({tag, "_index"}, b, {27'd0, m_index}, b);
    chk({tag, "_last"},  b, {31'd0, m_last}, (b == BEATS-1) ? 32'd1 : 32'd0);
  endtask

  // Full frame with m_ready held high; ends with m_valid low
  task automatic send_frame(input string tag, input logic [31:0] base, input bit ones);
    load(base, ones);
    feat_valid = 1'b1;
    m_ready    = 1'b1;
    tick;
    feat_valid = 1'b0;
    for (int b = 0; b < BEATS; b++) begin
      check_beat(tag, b, base, ones);
      tick;
    end
    chk({tag, "_vld_after"}, 0, {31'd0, m_valid}, 32'd0);
    chk({tag, "_busy_after"}, 0, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    bit pat [4];
    int e, cyc;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    rst_n = 1'b0; en = 1'b1; feat_valid = 1'b0; m_ready = 1'b0; feat_vec = '0;
    tick; tick;
    chk("rst_data",  0, m_data, 32'd0);
    chk("rst_index", 0, {27'd0, m_index}, 32'd0);
    chk("rst_valid", 0, {31'd0, m_valid}, 32'd0);
    chk("rst_last",  0, {31'd0, m_last}, 32'd0);
    chk("rst_busy",  0, {31'd0, busy}, 32'd0);
    chk("rst_drop",  0, {24'd0, drop_cnt}, 32'd0);
    rst_n = 1'b1;
    tick;

    // 1: words 1..27 streamed back to back
    send_frame("t1", 32'd1, 1'b0);

    // 2: m_ready pattern 1,0,0,1 -- words held while stalled
    load(32'd100, 1'b0);
    feat_valid = 1'b1;
    tick;
    feat_valid = 1'b0;
    e = 0; cyc = 0;
    while (e < BEATS && cyc < 200) begin
      check_beat("t2", e, 32'd100, 1'b0);
      m_ready = pat[cyc % 4];
      if (m_ready) e++;
      cyc++;
      tick;
    end
    chk("t2_done", 0, e, BEATS);
    chk("t2_vld_after", 0, {31'd0, m_valid}, 32'd0);

    // 3: overrun at beat 10 is dropped, current frame intact
    m_ready = 1'b1;
    load(32'd200, 1'b0);
    feat_valid = 1'b1;
    tick;
    feat_valid = 1'b0;
    for (int b = 0; b < BEATS; b++) begin
      check_beat("t3", b, 32'd200, 1'b0);
      feat_valid = (b == 10);
      if (b == 10) load(32'd900, 1'b0);
      tick;
    end
    chk("t3_vld_after", 0, {31'd0, m_valid}, 32'd0);
    chk("t3_drop", 0, {24'd0, drop_cnt}, 32'd1);

    // 4: start on the last beat -> next frame follows without a gap
    load(32'd300, 1'b0);
    feat_valid = 1'b1;
    tick;
    feat_valid = 1'b0;
    for (int b = 0; b < BEATS; b++) begin
      check_beat("t4a", b, 32'd300, 1'b0);
      if (b == BEATS-1) begin
        load(32'd400, 1'b0);
        feat_valid = 1'b1;
      end
      tick;
    end
    feat_valid = 1'b0;
    for (int b = 0; b < BEATS; b++) begin
      check_beat("t4b", b, 32'd400, 1'b0);
      tick;
    end
    chk("t4_vld_after", 0, {31'd0, m_valid}, 32'd0);
    chk("t4_drop", 0, {24'd0, drop_cnt}, 32'd1);

    // 5: async reset mid-frame, then a clean frame
    load(32'd500, 1'b0);
    feat_valid = 1'b1;
    tick;
    feat_valid = 1'b0;
    for (int b = 0; b <= 13; b++) begin
      check_beat("t5", b, 32'd500, 1'b0);
      if (b < 13) tick;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_data",  0, m_data, 32'd0);
    chk("t5_rst_index", 0, {27'd0, m_index}, 32'd0);
    chk("t5_rst_valid", 0, {31'd0, m_valid}, 32'd0);
    chk("t5_rst_last",  0, {31'd0, m_last}, 32'd0);
    chk("t5_rst_busy",  0, {31'd0, busy}, 32'd0);
    chk("t5_rst_drop",  0, {24'd0, drop_cnt}, 32'd0);
    tick;
    rst_n = 1'b1;
    tick;
    send_frame("t5b", 32'd600, 1'b0);

    // 6: en low ignores edges; level already high when en rises is not a start
    en = 1'b0;
    tick;
    feat_valid = 1'b1;
    tick;
    chk("t6_en0_valid", 0, {31'd0, m_valid}, 32'd0);
    tick;
    chk("t6_en0_busy", 1, {31'd0, busy}, 32'd0);
    en = 1'b1;
    tick;
    chk("t6_enrise_valid", 0, {31'd0, m_valid}, 32'd0);
    tick;
    chk("t6_enrise_valid", 1, {31'd0, m_valid}, 32'd0);
    feat_valid = 1'b0;
    tick;
    chk("t6_busy", 0, {31'd0, busy}, 32'd0);
`ifdef FEAT_SER_CHECKSUM_EN
    send_frame("t6_ones", 32'd0, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
